// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data bus sequencer.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } state_t;

  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    case (size)
      SIZE_WORD: return 4'b1111;
      SIZE_HALF: return 4'b0011;
      SIZE_BYTE: return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  // An access crosses a word boundary when its shifted mask spills into the next word.
  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] offset);
    logic [7:0] wide;
    wide = {4'b0000, size_to_mask(size)} << offset;
    return wide[7:4] != 4'b0000;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / data shifting per beat and load data extraction.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        beat,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata
);

  logic [4:0]  shamt;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [31:0] rd_word;

  assign shamt    = {offset, 3'b000};
  assign be_wide  = {4'b0000, size_to_mask(size)} << offset;
  assign wd_wide  = {32'h0000_0000, wdata} << shamt;
  assign rd_word  = 32'(rword >> shamt);

  // The upper half of each widened vector is exactly what the second beat carries.
  assign be       = beat ? be_wide[7:4] : be_wide[3:0];
  assign wdata_sh = beat ? wd_wide[63:32] : wd_wide[31:0];

  always_comb begin
    rdata = rd_word;
    case (size)
      SIZE_HALF: rdata = {{16{rd_word[15] & ~is_unsigned}}, rd_word[15:0]};
      SIZE_BYTE: rdata = {{24{rd_word[7] & ~is_unsigned}}, rd_word[7:0]};
      SIZE_NONE: rdata = 32'h0000_0000;
      default:   rdata = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage access sequencer: req/ack bus beats, misaligned splitting and ack watchdog.
// Optional macro MISALIGN_TRAP_EN faults word-crossing accesses instead of splitting them.
module mem_access_seq
  import mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  state_t            state, state_next;
  logic [1:0]        size_q, off_q;
  logic              write_q, unsigned_q, fault_q;
  logic [ADDR_W-3:0] word_q, word_next;
  logic [31:0]       wdata_q, d0_q, d1_q, wd_cnt;
  logic              active, in_beat, timeout;
  logic [3:0]        beat_be;
  logic [31:0]       beat_wdata, rdata_ext;
`ifdef MISALIGN_TRAP_EN
  logic              crossing_req;
  assign crossing_req = crosses_word(req_size, req_addr[1:0]);
`endif

  assign active    = req_valid && (req_size != SIZE_NONE);
  assign in_beat   = (state == BEAT0) || (state == BEAT1);
  assign word_next = word_q + (ADDR_W-2)'(1);
  assign timeout   = (ACK_TIMEOUT != 0) && in_beat && !bus_ack &&
                     (wd_cnt == 32'(ACK_TIMEOUT - 1));

  mem_lane_align u_align (
    .size        (size_q),
    .offset      (off_q),
    .beat        (state == BEAT1),
    .wdata       (wdata_q),
    .rword       ({d1_q, d0_q}),
    .is_unsigned (unsigned_q),
    .be          (beat_be),
    .wdata_sh    (beat_wdata),
    .rdata       (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (active) begin
`ifdef MISALIGN_TRAP_EN
          state_next = crossing_req ? RESP : BEAT0;
`else
          state_next = BEAT0;
`endif
        end
      end
      BEAT0: begin
        if (bus_ack)      state_next = crosses_word(size_q, off_q) ? BEAT1 : RESP;
        else if (timeout) state_next = RESP;
      end
      BEAT1: begin
        if (bus_ack || timeout) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once in IDLE; the watchdog restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q     <= SIZE_WORD;
      off_q      <= 2'b00;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      fault_q    <= 1'b0;
      word_q     <= '0;
      wdata_q    <= 32'h0;
      d0_q       <= 32'h0;
      d1_q       <= 32'h0;
      wd_cnt     <= 32'h0;
    end else begin
      if (state_next != state) wd_cnt <= 32'h0;
      else if (in_beat)        wd_cnt <= wd_cnt + 32'd1;

      if (state == IDLE && active) begin
        size_q     <= req_size;
        off_q      <= req_addr[1:0];
        word_q     <= req_addr[ADDR_W-1:2];
        write_q    <= req_write;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
`ifdef MISALIGN_TRAP_EN
        fault_q    <= crossing_req;
`else
        fault_q    <= 1'b0;
`endif
      end else if (timeout) begin
        fault_q <= 1'b1;
      end

      if (state == BEAT0 && bus_ack) d0_q <= bus_rdata;
      if (state == BEAT1 && bus_ack) d1_q <= bus_rdata;
    end
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = 32'h0;
    done      = 1'b0;
    fault     = 1'b0;
    rdata     = 32'h0;
    case (state)
      BEAT0: begin
        bus_req   = 1'b1;
        bus_we    = write_q;
        bus_addr  = {word_q, 2'b00};
        bus_be    = beat_be;
        bus_wdata = beat_wdata;
      end
      BEAT1: begin
        bus_req   = 1'b1;
        bus_we    = write_q;
        bus_addr  = {word_next, 2'b00};
        bus_be    = beat_be;
        bus_wdata = beat_wdata;
      end
      RESP: begin
        done  = 1'b1;
        fault = fault_q;
        if (!fault_q && !write_q) rdata = rdata_ext;
      end
      default: ;
    endcase
  end

  assign stall = active && !done;

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequences every data-memory access of the MEM stage onto a single-port, word-wide data bus with a req/ack handshake and a variable wait-state count.
- Consumes the access_size / write / require-access decode produced for each load and store.
- Generates byte enables and lane shifting, and splits word-crossing misaligned accesses into two aligned beats.
- Stalls the pipeline until the access completes, and guards against a hung bus with a watchdog.

Parameters:
ACK_TIMEOUT, 255, max cycles bus_req may wait for bus_ack per beat; 0 disables watchdog
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  MEM stage needs a memory access (require_mem_access)
req_write  in  1  1=store, 0=load
req_size  in  2  00 word, 01 half, 10 byte, 11 none
req_unsigned  in  1  load zero-extends (LBU/LHU); ignored for word and stores
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  hold pipeline
done  out  1  one-cycle pulse: access finished
rdata  out  32  extended load data, valid when done
fault  out  1  with done: access aborted
bus_req  out  1  beat request
bus_we  out  1  beat is a write
bus_addr  out  ADDR_W  word-aligned beat address (bits[1:0]=00)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-shifted write data
bus_ack  in  1  beat accepted/completed; bus_rdata valid same cycle
bus_rdata  in  32  read word

Behaviour:
- Clock clk, reset rst: one clock; rst is asynchronous, active-high.
- Reset:
  - state IDLE.
  - stall, done, fault, bus_req, bus_we = 0.
  - bus_addr, bus_be, bus_wdata, rdata = 0.
  - Reset mid-beat drops bus_req immediately; a partially written split store is not rolled back.
- Request decode:
  - Size n = 4/2/1 bytes; o = req_addr[1:0]; word address W = req_addr[ADDR_W-1:2].
  - Request is active when req_valid = 1 and req_size != 11.
  - Upstream holds all req_* stable while stall = 1.
- stall = active request AND NOT done (combinational). stall is 0 in the done cycle.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
  - IDLE → BEAT0 on active request; request fields are latched.
  - BEAT0:
    - bus_req = 1, bus_addr = W<<2, bus_be = (mask_n << o)[3:0], bus_wdata = req_wdata << 8*o.
    - On bus_ack: go to BEAT1 if o+n > 4, else RESP.
  - BEAT1:
    - bus_addr = ((W+1) mod 2^(ADDR_W-2)) << 2; wraps at 0xFFFFFFFC → 0x00000000.
    - bus_be = mask_n >> (4-o); bus_wdata = req_wdata >> 8*(4-o).
    - On bus_ack: go to RESP.
  - RESP: done = 1 for one cycle, then IDLE. There is always one idle cycle between accesses.
- Bus handshake:
  - bus_addr, bus_we, bus_be and bus_wdata stay stable while bus_req = 1 and bus_ack = 0.
  - An ack in the first bus_req cycle is legal (zero wait).
  - bus_ack is ignored when bus_req = 0.
- Load assembly:
  - Beat read data D0 (BEAT0) and D1 (BEAT1) are registered on their acks.
  - rdata = low n bytes of ({D1,D0} >> 8*o).
  - Byte and half loads are sign-extended unless req_unsigned = 1.
  - Stores drive rdata = 0.
- Latency: aligned access with zero wait → done 2 cycles after the request is first seen; a split access adds 1 cycle per beat.
- Watchdog:
  - A per-beat counter resets on beat entry.
  - If it reaches ACK_TIMEOUT without bus_ack: drop bus_req, go RESP, fault = 1, rdata = 0.
- Inactive request (req_size = 11, or req_valid = 0): no bus activity, stall = 0, done = 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a word-crossing access (o+n > 4) issues no bus beat. FSM goes IDLE → RESP directly; done = 1, fault = 1, rdata = 0; stall is high for 1 cycle.
- Undefined: crossing accesses are split into two beats as above.
- Non-crossing misaligned accesses (e.g. half at o = 1) are legal in both configurations.

Decomposition:
- Package mem_pkg:
  - Size encodings SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10, SIZE_NONE = 2'b11.
  - FSM state encoding.
  - Function size_to_mask (n → 4-bit mask).
- One combinational sub-module, mem_lane_align:
  - Given size, offset, beat index and wdata, produces be and shifted wdata.
  - Given {D1,D0}, size, offset and unsigned flag, produces extended rdata.
- The FSM and watchdog stay in mem_access_seq.

Test Plan:
- LW at 0x100, ack on first cycle, bus_rdata = 0xDEADBEEF → bus_addr = 0x100, be = 1111, done 2 cycles after request, rdata = 0xDEADBEEF, fault = 0.
- LB at 0x203, bus_rdata = 0x80xxxxxx → be = 1000, rdata = 0xFFFFFF80. LBU at the same address → rdata = 0x00000080.
- SW 0x11223344 at 0x102, split (macro undefined), 2 wait states per beat:
  - beat0 addr 0x100, be = 1100, wdata = 0x33440000.
  - beat1 addr 0x104, be = 0011, wdata = 0x00001122.
  - done after 7 cycles.
- LH at 0xFFFFFFFF with D0 = 0xAB000000 and D1 = 0x000000CD → beat1 addr 0x00000000, rdata = 0xFFFFCDAB.
- ACK_TIMEOUT = 4, bus_ack held 0 → bus_req high 4 cycles then drops; done = 1, fault = 1, rdata = 0. Also: rst asserted mid-beat → bus_req = 0 immediately.
- With MISALIGN_TRAP_EN, LW at 0x101 → no bus_req ever, done = 1 with fault = 1 one cycle after request.
